decodificador_pwm: RTL

//  Receive side of the servo PWM interface: measures pulse width (high time) and period of
//  an external PWM input, e.g. an RC receiver channel or a looped-back circuito_pwm output.

---
 rtl/decodificador_pwm.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/decodificador_pwm.sv
// PWM receiver: measures high time and rising-to-rising period of an asynchronous
// PWM input and publishes one registered measurement per complete period.
module decodificador_pwm #(
  parameter int TIMEOUT  = 2_000_000,
  parameter int LARG_MIN = 25_000,
  parameter int LARG_MAX = 125_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [16:0] largura,
  output logic [20:0] periodo,
  output logic        pronto,
  output logic        valido,
  output logic        fora_faixa,
  output logic        sem_sinal
);

  localparam logic [20:0] LIMITE    = 21'(TIMEOUT);
  localparam logic [16:0] LARG_BAIX = 17'(LARG_MIN);
  localparam logic [16:0] LARG_ALTA = 17'(LARG_MAX);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ALTO   = 2'd1,
    BAIXO  = 2'd2
  } estado_t;

  estado_t     estado;
  estado_t     prox;
  logic        pwm_p0;
  logic        pwm_p1;
  logic        pwm_p2;
  logic        subida;
  logic        descida;
  logic [20:0] cont;
  logic        cont_fim;
  logic [16:0] larg_tmp;
  logic        publica;
  logic        captura;
  logic        expira;

  // A count that does not fit the width output is clipped instead of wrapping.
  function automatic logic [16:0] sat_largura(input logic [20:0] valor);
    if (valor > 21'h01FFFF)
      return 17'h1FFFF;
    else
      return valor[16:0];
  endfunction

  function automatic logic fora_limites(input logic [16:0] larg);
    return (larg < LARG_BAIX) || (larg > LARG_ALTA);
  endfunction

  // Stage p0/p1: synchroniser; p2: edge history. Preset high so a line already high
  // when reset is released is not mistaken for a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_p0 <= 1'b1;
      pwm_p1 <= 1'b1;
      pwm_p2 <= 1'b1;
    end else begin
      pwm_p0 <= pwm_in;
      pwm_p1 <= pwm_p0;
      pwm_p2 <= pwm_p1;
    end
  end

  assign subida   = pwm_p1 & ~pwm_p2;
  assign descida  = ~pwm_p1 & pwm_p2;
  assign cont_fim = (cont == LIMITE);

  // Cycle counter: holds k on the k-th cycle after the synchronised rising edge.
  always_ff @(posedge clock) begin
    if (subida)
      cont <= 21'd1;
    else if (cont < LIMITE)
      cont <= cont + 21'd1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      estado <= ESPERA;
    else
      estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      ESPERA: if (subida) prox = ALTO;
      ALTO: begin
        if (descida)
          prox = BAIXO;
        else if (cont_fim)
          prox = ESPERA;
      end
      BAIXO: begin
        if (subida)
          prox = ALTO;
        else if (cont_fim)
          prox = ESPERA;
      end
      default: prox = ESPERA;
    endcase
  end

  // A rising edge on the same cycle as the limit still closes a valid period.
  always_comb begin
    publica = 1'b0;
    captura = 1'b0;
    expira  = 1'b0;
    case (estado)
      ALTO: begin
        captura = descida;
        expira  = ~descida & cont_fim;
      end
      BAIXO: begin
        publica = subida;
        expira  = ~subida & cont_fim;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (captura)
      larg_tmp <= sat_largura(cont);
  end

  // Publication stage: everything visible downstream changes together here.
  always_ff @(posedge clock) begin
    if (reset) begin
      largura    <= '0;
      periodo    <= '0;
      pronto     <= 1'b0;
      valido     <= 1'b0;
      fora_faixa <= 1'b0;
      sem_sinal  <= 1'b0;
    end else begin
      pronto <= publica;
      if (publica) begin
        largura    <= larg_tmp;
        periodo    <= cont;
        fora_faixa <= fora_limites(larg_tmp);
        valido     <= 1'b1;
        sem_sinal  <= 1'b0;
      end else if (expira) begin
        valido    <= 1'b0;
        sem_sinal <= 1'b1;
      end
    end
  end

endmodule
